djb2_stream_ctrl: RTL

- Sequencer that feeds a byte stream into the team's djb2 hash core (4-bit cmd / 28-bit packed-data interface) and returns one 32-bit hash per string.
- Accepts ASCII bytes on a valid/ready stream with a last flag.
- Packs up to 4 seven-bit chars per chunk, issues each chunk with a single-cycle enable pulse, and paces the core by cycle count.
- Presents the final hash on a valid/ready output. Sits between the AXI-side byte FIFO and the hash core instance.

---
 rtl/djb2_ctrl_pkg.sv | 28 ++
 rtl/djb2_stream_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/djb2_ctrl_pkg.sv
// Shared types and constants for the djb2 stream controller: FSM states,
// hash core command bit positions, chunk geometry and the djb2 seed value.
package djb2_ctrl_pkg;

  typedef enum logic [2:0] {
    CLEAR   = 3'd0,
    COLLECT = 3'd1,
    ISSUE   = 3'd2,
    CALC    = 3'd3,
    OUT     = 3'd4
  } state_t;

  localparam int CMD_RST    = 3;
  localparam int CMD_EN     = 2;
  localparam int CMD_LEN_HI = 1;
  localparam int CMD_LEN_LO = 0;

  localparam int CHARS_PER_CHUNK = 4;
  localparam int CHAR_W          = 7;
  localparam int DATA_W          = CHARS_PER_CHUNK * CHAR_W;

  localparam logic [31:0] HASH_INIT = 32'd5381;

  function automatic logic [3:0] make_cmd(input logic rst, input logic en, input logic [1:0] len);
    return {rst, en, len};
  endfunction

endpackage

// File: rtl/djb2_stream_ctrl.sv
// Sequencer between a byte stream and the djb2 hash core: packs up to four
// 7-bit chars per chunk, pulses the core enable once per chunk, returns the hash.
module djb2_stream_ctrl
  import djb2_ctrl_pkg::*;
#(
  parameter int STR_CNT_W  = 16,
  parameter bit CHECK_BUSY = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [7:0]           s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [31:0]          m_hash,
  output logic                 m_err,
  output logic [3:0]           hash_cmd,
  output logic [DATA_W-1:0]    hash_data,
  input  logic [31:0]          hash_hashed,
  input  logic                 hash_busy,
  output logic                 proto_err,
  output logic [STR_CNT_W-1:0] str_cnt
);

  state_t                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [1:0]             len_q, len_d;
  logic [1:0]             calc_q, calc_d;
  logic                   last_q, last_d;
  logic                   err_q, err_d;
  logic                   proto_err_q, proto_err_d;
  logic [STR_CNT_W-1:0]   str_cnt_q, str_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      data_q      <= '0;
      len_q       <= '0;
      calc_q      <= '0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      proto_err_q <= 1'b0;
      str_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      len_q       <= len_d;
      calc_q      <= calc_d;
      last_q      <= last_d;
      err_q       <= err_d;
      proto_err_q <= proto_err_d;
      str_cnt_q   <= str_cnt_d;
    end
  end

  // len and data must stay frozen through CALC because the core re-reads them each cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    len_d       = len_q;
    calc_d      = calc_q;
    last_d      = last_q;
    err_d       = err_q;
    proto_err_d = proto_err_q;
    str_cnt_d   = str_cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d   = '0;
        data_d  = '0;
        len_d   = '0;
        last_d  = 1'b0;
        state_d = COLLECT;
      end
      COLLECT: begin
        if (s_valid) begin
          for (int k = 0; k < CHARS_PER_CHUNK; k++) begin
            if (cnt_q[1:0] == 2'(k)) begin
              data_d[k*CHAR_W +: CHAR_W] = s_data[CHAR_W-1:0];
            end
          end
          cnt_d = cnt_q + 3'd1;
          err_d = err_q | s_data[7];
          if (s_last || (cnt_q == 3'd3)) begin
            len_d   = cnt_q[1:0];
            last_d  = s_last;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        calc_d  = len_q;
        state_d = CALC;
        if (CHECK_BUSY && hash_busy) begin
          proto_err_d = 1'b1;
        end
      end
      CALC: begin
        if (calc_q == 2'd0) begin
          if (last_q) begin
            state_d = OUT;
          end else begin
            cnt_d   = '0;
            data_d  = '0;
            state_d = COLLECT;
          end
        end else begin
          calc_d = calc_q - 2'd1;
        end
      end
      OUT: begin
        if (m_ready) begin
          str_cnt_d = str_cnt_q + STR_CNT_W'(1);
          err_d     = 1'b0;
          state_d   = CLEAR;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    s_ready  = 1'b0;
    m_valid  = 1'b0;
    m_err    = 1'b0;
    m_hash   = '0;
    hash_cmd = make_cmd(1'b0, 1'b0, len_q);
    case (state_q)
      CLEAR:   hash_cmd = make_cmd(1'b1, 1'b0, 2'd0);
      COLLECT: s_ready  = 1'b1;
      ISSUE:   hash_cmd = make_cmd(1'b0, 1'b1, len_q);
      CALC:    hash_cmd = make_cmd(1'b0, 1'b0, len_q);
      OUT: begin
        m_valid = 1'b1;
        m_hash  = hash_hashed;
        m_err   = err_q;
      end
      default: hash_cmd = make_cmd(1'b1, 1'b0, 2'd0);
    endcase
  end

  assign hash_data = data_q;
  assign proto_err = proto_err_q;
  assign str_cnt   = str_cnt_q;

endmodule
